pwm_reg_arbiter: RTL and testbench

PWM_REG_ARBITER -- requirements
Module: pwm_reg_arbiter

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_rr_arb2.sv | 36 +++
 rtl/pwm_reg_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_pwm_reg_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM register arbiter: FSM states, address map
// constants and the address-range helper used by the optional address check.
package pwm_pkg;

  localparam int unsigned ADDR_W = 8;

  localparam logic [ADDR_W-1:0] ADDR_CTRL     = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ADDR_HOLE     = ADDR_W'(9);
  localparam logic [ADDR_W-1:0] ADDR_FIRST_CH = ADDR_W'(10);
  localparam logic [ADDR_W-1:0] ADDR_LAST     = ADDR_W'(41);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } pwm_arb_state_t;

  // True for addresses backed by a register (everything up to ADDR_LAST except the hole).
  function automatic logic addr_valid(input logic [ADDR_W-1:0] addr);
    return (addr != ADDR_HOLE) && (addr <= ADDR_LAST);
  endfunction

endpackage

// File: rtl/pwm_rr_arb2.sv
// Two-way round-robin selector with a last-grant pointer.
// Index 0 selects requester 0, index 1 selects requester 1.
module pwm_rr_arb2
  import pwm_pkg::*;
(
  input  logic clk_psc_i,
  input  logic rst_n_i,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_update,
  output logic o_gnt_valid_c,
  output logic o_gnt_idx_c
);

  logic r_last;

  // Lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    o_gnt_valid_c = i_req0 | i_req1;
    if (i_req0 && i_req1) begin
      o_gnt_idx_c = ~r_last;
    end else begin
      o_gnt_idx_c = i_req1;
    end
  end

  // Pointer resets to requester 1 so requester 0 takes the first tie.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_last <= 1'b1;
    end else if (i_update && o_gnt_valid_c) begin
      r_last <= o_gnt_idx_c;
    end
  end

endmodule

// File: rtl/pwm_reg_arbiter.sv
// Two-requester arbiter in front of the PWM register block.
// One transaction at a time: IDLE (arbitrate/latch) -> ISSUE (strobe) -> RESP (ack).
// Optional build macro PWM_ARB_ADDR_CHECK_EN: unmapped addresses get no strobe
// and are answered with err=1; without it every address is forwarded.
module pwm_reg_arbiter
  import pwm_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic              clk_psc_i,
  input  logic              rst_n_i,
  input  logic              req0_i,
  input  logic              we0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [WIDTH-1:0]  wdata0_i,
  input  logic              req1_i,
  input  logic              we1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [WIDTH-1:0]  wdata1_i,
  output logic              ack0_o,
  output logic [WIDTH-1:0]  rdata0_o,
  output logic              err0_o,
  output logic              ack1_o,
  output logic [WIDTH-1:0]  rdata1_o,
  output logic              err1_o,
  output logic              reg_wr_en_o,
  output logic              reg_rd_en_o,
  output logic [ADDR_W-1:0] reg_addr_o,
  output logic [WIDTH-1:0]  reg_wr_data_o,
  input  logic [WIDTH-1:0]  reg_rd_data_i
);

  pwm_arb_state_t    r_state;
  pwm_arb_state_t    w_state_nxt;

  logic              w_gnt_valid;
  logic              w_gnt_idx;
  logic              w_update;

  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [WIDTH-1:0]  w_sel_wdata;
  logic              w_sel_ok;

  logic              r_winner;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [WIDTH-1:0]  r_wdata;
  logic              r_addr_ok;

  logic              r_wr_en;
  logic              r_rd_en;
  logic              r_ack0;
  logic              r_ack1;
  logic              r_err0;
  logic              r_err1;
  logic [WIDTH-1:0]  r_rdata0;
  logic [WIDTH-1:0]  r_rdata1;

  logic              w_wr_en_nxt;
  logic              w_rd_en_nxt;
  logic              w_ack0_nxt;
  logic              w_ack1_nxt;
  logic              w_err0_nxt;
  logic              w_err1_nxt;
  logic [WIDTH-1:0]  w_rdata0_nxt;
  logic [WIDTH-1:0]  w_rdata1_nxt;
  logic [WIDTH-1:0]  w_rdata_cap;

  pwm_rr_arb2 u_rr (
    .clk_psc_i     (clk_psc_i),
    .rst_n_i       (rst_n_i),
    .i_req0        (req0_i),
    .i_req1        (req1_i),
    .i_update      (w_update),
    .o_gnt_valid_c (w_gnt_valid),
    .o_gnt_idx_c   (w_gnt_idx)
  );

  // Mux the winning requester's transaction fields.
  always_comb begin
    w_sel_we    = w_gnt_idx ? we1_i    : we0_i;
    w_sel_addr  = w_gnt_idx ? addr1_i  : addr0_i;
    w_sel_wdata = w_gnt_idx ? wdata1_i : wdata0_i;
  end

`ifdef PWM_ARB_ADDR_CHECK_EN
  assign w_sel_ok = addr_valid(w_sel_addr);
`else
  assign w_sel_ok = 1'b1;
`endif

  // FSM next state plus next values of the registered outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_update     = 1'b0;
    w_wr_en_nxt  = 1'b0;
    w_rd_en_nxt  = 1'b0;
    w_ack0_nxt   = 1'b0;
    w_ack1_nxt   = 1'b0;
    w_err0_nxt   = 1'b0;
    w_err1_nxt   = 1'b0;
    w_rdata0_nxt = '0;
    w_rdata1_nxt = '0;
    w_rdata_cap  = (!r_we && r_addr_ok) ? reg_rd_data_i : '0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_state_nxt = ISSUE;
          w_update    = 1'b1;
          w_wr_en_nxt = w_sel_we & w_sel_ok;
          w_rd_en_nxt = ~w_sel_we & w_sel_ok;
        end
      end
      ISSUE: begin
        w_state_nxt = RESP;
        if (r_winner) begin
          w_ack1_nxt   = 1'b1;
          w_err1_nxt   = ~r_addr_ok;
          w_rdata1_nxt = w_rdata_cap;
        end else begin
          w_ack0_nxt   = 1'b1;
          w_err0_nxt   = ~r_addr_ok;
          w_rdata0_nxt = w_rdata_cap;
        end
      end
      RESP: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the winner's transaction on the IDLE->ISSUE transition.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_winner  <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_addr_ok <= 1'b0;
    end else if (w_update) begin
      r_winner  <= w_gnt_idx;
      r_we      <= w_sel_we;
      r_addr    <= w_sel_addr;
      r_wdata   <= w_sel_wdata;
      r_addr_ok <= w_sel_ok;
    end
  end

  // Registered strobes and responses; reset clears them asynchronously.
  always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_en  <= 1'b0;
      r_rd_en  <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_err0   <= 1'b0;
      r_err1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_wr_en  <= w_wr_en_nxt;
      r_rd_en  <= w_rd_en_nxt;
      r_ack0   <= w_ack0_nxt;
      r_ack1   <= w_ack1_nxt;
      r_err0   <= w_err0_nxt;
      r_err1   <= w_err1_nxt;
      r_rdata0 <= w_rdata0_nxt;
      r_rdata1 <= w_rdata1_nxt;
    end
  end

  assign reg_wr_en_o   = r_wr_en;
  assign reg_rd_en_o   = r_rd_en;
  assign reg_addr_o    = r_addr;
  assign reg_wr_data_o = r_wdata;
  assign ack0_o        = r_ack0;
  assign ack1_o        = r_ack1;
  assign err0_o        = r_err0;
  assign err1_o        = r_err1;
  assign rdata0_o      = r_rdata0;
  assign rdata1_o      = r_rdata1;

endmodule

// File: tb/tb_pwm_reg_arbiter.sv
// Directed bench for pwm_reg_arbiter with a simple register-block memory model.
module tb_pwm_reg_arbiter;

  localparam int unsigned WIDTH = 16;
`ifdef PWM_ARB_ADDR_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk_psc_i = 1'b0;
  logic              rst_n_i;
  logic              req0_i, we0_i, req1_i, we1_i;
  logic [7:0]        addr0_i, addr1_i;
  logic [WIDTH-1:0]  wdata0_i, wdata1_i;
  logic              ack0_o, ack1_o, err0_o, err1_o;
  logic [WIDTH-1:0]  rdata0_o, rdata1_o;
  logic              reg_wr_en_o, reg_rd_en_o;
  logic [7:0]        reg_addr_o;
  logic [WIDTH-1:0]  reg_wr_data_o;
  logic [WIDTH-1:0]  reg_rd_data_i;

  logic [WIDTH-1:0]  mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_psc_i = ~clk_psc_i;

  pwm_reg_arbiter #(.WIDTH(WIDTH)) dut (
    .clk_psc_i     (clk_psc_i),
    .rst_n_i       (rst_n_i),
    .req0_i        (req0_i),
    .we0_i         (we0_i),
    .addr0_i       (addr0_i),
    .wdata0_i      (wdata0_i),
    .req1_i        (req1_i),
    .we1_i         (we1_i),
    .addr1_i       (addr1_i),
    .wdata1_i      (wdata1_i),
    .ack0_o        (ack0_o),
    .rdata0_o      (rdata0_o),
    .err0_o        (err0_o),
    .ack1_o        (ack1_o),
    .rdata1_o      (rdata1_o),
    .err1_o        (err1_o),
    .reg_wr_en_o   (reg_wr_en_o),
    .reg_rd_en_o   (reg_rd_en_o),
    .reg_addr_o    (reg_addr_o),
    .reg_wr_data_o (reg_wr_data_o),
    .reg_rd_data_i (reg_rd_data_i)
  );

  // Register block model: combinational read, write on the strobe.
  assign reg_rd_data_i = mem[reg_addr_o];
  always @(posedge clk_psc_i) begin
    if (reg_wr_en_o) mem[reg_addr_o] <= reg_wr_data_o;
  end

  task automatic tick();
    @(posedge clk_psc_i);
    #1;
  endtask

  task automatic idle_inputs();
    req0_i = 1'b0; we0_i = 1'b0; addr0_i = '0; wdata0_i = '0;
    req1_i = 1'b0; we1_i = 1'b0; addr1_i = '0; wdata1_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_psc_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n_i = 1'b0;
    #12;
    n_tests++;
    if ({ack0_o, ack1_o, err0_o, err1_o, reg_wr_en_o, reg_rd_en_o} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b exp 000000",
               {ack0_o, ack1_o, err0_o, err1_o, reg_wr_en_o, reg_rd_en_o});
    end
    n_tests++;
    if ({rdata0_o, rdata1_o, reg_addr_o, reg_wr_data_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h exp 0", {rdata0_o, rdata1_o, reg_addr_o, reg_wr_data_o});
    end
    @(negedge clk_psc_i);
    rst_n_i = 1'b1;
    tick();
    n_tests++;
    if ({ack0_o, ack1_o, reg_wr_en_o, reg_rd_en_o} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got %b exp 0000", {ack0_o, ack1_o, reg_wr_en_o, reg_rd_en_o});
    end
  endtask

  task automatic test_single_write();
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 8'd2; wdata0_i = 16'h1234;
    tick();
    n_tests++;
    if ({reg_wr_en_o, reg_rd_en_o, reg_addr_o, reg_wr_data_o} !== {2'b10, 8'd2, 16'h1234}) begin
      n_fail++;
      $display("FAIL wr_issue: got we=%b re=%b a=%0d d=%h exp we=1 re=0 a=2 d=1234",
               reg_wr_en_o, reg_rd_en_o, reg_addr_o, reg_wr_data_o);
    end
    n_tests++;
    if ({ack0_o, ack1_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL wr_early_ack: got %b exp 00", {ack0_o, ack1_o});
    end
    tick();
    n_tests++;
    if ({ack0_o, err0_o, ack1_o, reg_wr_en_o, rdata0_o} !== {4'b1000, 16'h0000}) begin
      n_fail++;
      $display("FAIL wr_resp: got ack0=%b err0=%b ack1=%b we=%b rd0=%h exp 1 0 0 0 0000",
               ack0_o, err0_o, ack1_o, reg_wr_en_o, rdata0_o);
    end
    req0_i = 1'b0;
    tick();
    n_tests++;
    if (ack0_o !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_ack_pulse: got %b exp 0", ack0_o);
    end
  endtask

  task automatic test_single_read();
    req1_i = 1'b1; we1_i = 1'b0; addr1_i = 8'd12;
    tick();
    n_tests++;
    if ({reg_rd_en_o, reg_wr_en_o, reg_addr_o} !== {2'b10, 8'd12}) begin
      n_fail++;
      $display("FAIL rd_issue: got re=%b we=%b a=%0d exp re=1 we=0 a=12",
               reg_rd_en_o, reg_wr_en_o, reg_addr_o);
    end
    tick();
    n_tests++;
    if ({ack1_o, err1_o, ack0_o, reg_rd_en_o, rdata1_o} !== {4'b1000, 16'h0001}) begin
      n_fail++;
      $display("FAIL rd_resp: got ack1=%b err1=%b ack0=%b re=%b rd1=%h exp 1 0 0 0 0001",
               ack1_o, err1_o, ack0_o, reg_rd_en_o, rdata1_o);
    end
    req1_i = 1'b0;
    tick();
    n_tests++;
    if ({ack1_o, rdata1_o} !== '0) begin
      n_fail++;
      $display("FAIL rd_clear: got ack1=%b rd1=%h exp 0 0000", ack1_o, rdata1_o);
    end
  endtask

  task automatic test_tie_round_robin();
    do_reset();
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 8'd3;  wdata0_i = 16'hA5A5;
    req1_i = 1'b1; we1_i = 1'b0; addr1_i = 8'd12;
    for (int k = 0; k < 4; k++) begin
      logic exp_w;
      exp_w = k[0];
      tick();
      n_tests++;
      if (exp_w == 1'b0) begin
        if ({reg_wr_en_o, reg_rd_en_o, reg_addr_o, reg_wr_data_o} !== {2'b10, 8'd3, 16'hA5A5}) begin
          n_fail++;
          $display("FAIL tie_issue%0d: got we=%b re=%b a=%0d exp winner 0 we=1 a=3",
                   k, reg_wr_en_o, reg_rd_en_o, reg_addr_o);
        end
      end else begin
        if ({reg_wr_en_o, reg_rd_en_o, reg_addr_o} !== {2'b01, 8'd12}) begin
          n_fail++;
          $display("FAIL tie_issue%0d: got we=%b re=%b a=%0d exp winner 1 re=1 a=12",
                   k, reg_wr_en_o, reg_rd_en_o, reg_addr_o);
        end
      end
      tick();
      n_tests++;
      if ({ack0_o, ack1_o} !== {~exp_w, exp_w}) begin
        n_fail++;
        $display("FAIL tie_ack%0d: got ack0=%b ack1=%b exp winner %0d", k, ack0_o, ack1_o, exp_w);
      end
      if (exp_w) begin
        n_tests++;
        if (rdata1_o !== 16'h0001 || rdata0_o !== 16'h0000) begin
          n_fail++;
          $display("FAIL tie_rdata%0d: got rd0=%h rd1=%h exp 0000 0001", k, rdata0_o, rdata1_o);
        end
      end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_addr_check();
    logic [7:0]       a_tab [3];
    logic [WIDTH-1:0] d_tab [3];
    logic             bad_tab [3];
    a_tab = '{8'd9, 8'd42, 8'd41};
    d_tab = '{16'h0909, 16'h4242, 16'h4141};
    bad_tab = '{1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 3; k++) begin
      logic bad;
      logic [WIDTH-1:0] exp_rd;
      bad = bad_tab[k] & CHK;
      exp_rd = bad ? 16'h0000 : d_tab[k];
      req0_i = 1'b1; we0_i = 1'b0; addr0_i = a_tab[k];
      tick();
      n_tests++;
      if ({reg_rd_en_o, reg_wr_en_o} !== {~bad, 1'b0}) begin
        n_fail++;
        $display("FAIL addr%0d_strobe: got re=%b we=%b exp re=%b we=0",
                 a_tab[k], reg_rd_en_o, reg_wr_en_o, ~bad);
      end
      tick();
      n_tests++;
      if ({ack0_o, err0_o, rdata0_o} !== {1'b1, bad, exp_rd}) begin
        n_fail++;
        $display("FAIL addr%0d_resp: got ack=%b err=%b rd=%h exp 1 %b %h",
                 a_tab[k], ack0_o, err0_o, rdata0_o, bad, exp_rd);
      end
      req0_i = 1'b0;
      tick();
    end
  endtask

  task automatic test_reset_in_issue();
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 8'd5; wdata0_i = 16'hBEEF;
    tick();
    n_tests++;
    if (reg_wr_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_strobe: got %b exp 1", reg_wr_en_o);
    end
    #1 rst_n_i = 1'b0;
    #1;
    n_tests++;
    if ({reg_wr_en_o, reg_rd_en_o, reg_addr_o} !== {2'b00, 8'd0}) begin
      n_fail++;
      $display("FAIL rst_async_drop: got we=%b re=%b a=%0d exp 0 0 0",
               reg_wr_en_o, reg_rd_en_o, reg_addr_o);
    end
    idle_inputs();
    repeat (2) @(negedge clk_psc_i);
    rst_n_i = 1'b1;
    tick();
    n_tests++;
    if ({ack0_o, ack1_o, reg_wr_en_o} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_no_ack: got %b exp 000", {ack0_o, ack1_o, reg_wr_en_o});
    end
    n_tests++;
    if (mem[5] !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_no_write: got %h exp 0000", mem[5]);
    end
    req0_i = 1'b1; we0_i = 1'b1; addr0_i = 8'd6; wdata0_i = 16'h0606;
    req1_i = 1'b1; we1_i = 1'b0; addr1_i = 8'd12;
    tick();
    n_tests++;
    if ({reg_wr_en_o, reg_rd_en_o, reg_addr_o} !== {2'b10, 8'd6}) begin
      n_fail++;
      $display("FAIL rst_tie_winner: got we=%b re=%b a=%0d exp winner 0 we=1 a=6",
               reg_wr_en_o, reg_rd_en_o, reg_addr_o);
    end
    tick();
    n_tests++;
    if ({ack0_o, ack1_o} !== 2'b10) begin
      n_fail++;
      $display("FAIL rst_tie_ack: got %b exp 10", {ack0_o, ack1_o});
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[12] = 16'h0001;
    mem[9]  = 16'h0909;
    mem[41] = 16'h4141;
    mem[42] = 16'h4242;
    test_reset();
    test_single_write();
    test_single_read();
    test_tie_round_robin();
    test_addr_check();
    test_reset_in_issue();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
